gpio_irq: RTL and testbench

Bus-attached 8-bit input port that pairs with the GPIO output peripheral on the CPU data bus. It synchronises and debounces eight external pins, detects rising/falling edges under per-bit masks, latches them in a sticky status register and raises a level interrupt to the CPU. It is a Wishbone slave on the shared `wb_dbus` and drives zero on `rdt` when not selected, so its read data can be OR-combined with the other peripherals'.

---
 rtl/gpio_irq_pkg.sv | 14 +
 rtl/gpio_irq_if.sv | 13 +
 rtl/chip_select.sv | 32 +++
 rtl/debounce_bit.sv | 47 ++++
 rtl/gpio_irq.sv | 109 ++++++++++
 tb/tb_gpio_irq.sv | 257 +++++++++++++++++++++++++
 6 files changed

// File: rtl/gpio_irq_pkg.sv
// rtl/gpio_irq_pkg.sv - register indices and debounce counter sizing for gpio_irq
package gpio_irq_pkg;

    localparam logic [1:0] GPIO_IRQ_IN      = 2'd0;
    localparam logic [1:0] GPIO_IRQ_RISE_EN = 2'd1;
    localparam logic [1:0] GPIO_IRQ_FALL_EN = 2'd2;
    localparam logic [1:0] GPIO_IRQ_STATUS  = 2'd3;

    // Width needed to hold a debounce count of 0..debounce.
    function automatic int debounce_cnt_width(input int debounce);
        return $clog2(debounce + 1);
    endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// rtl/gpio_irq_if.sv - data bus signals shared between the CPU and its peripherals
interface gpio_irq_if;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, sel, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/chip_select.sv
// rtl/chip_select.sv - address decode and one-shot acknowledge for a bus slave
module chip_select #(
    parameter int ADDR   = 0,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] adr_hi,
    input  logic              req,
    output logic              cyc,
    output logic              ack
);

    logic match;
    logic busy;

    assign match = (adr_hi == AWIDTH'(ADDR));
    assign cyc   = ack;

    // One ack per bus cycle; busy holds off re-acks until req drops.
    // A cycle still open at reset is treated as already served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack  <= 1'b0;
            busy <= req;
        end else begin
            ack  <= req & match & ~busy;
            busy <= req & (busy | match);
        end
    end

endmodule

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser and stability filter for one pin
module debounce_bit
    import gpio_irq_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic filt
);

    localparam int             CW   = debounce_cnt_width(DEBOUNCE);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
        end
    end

    // Count consecutive cycles the synchronised value disagrees with the
    // filtered value; accept it once it has disagreed DEBOUNCE times running.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync == filt) begin
            cnt  <= '0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            filt <= sync;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - debounced 8-bit input port with edge-triggered sticky interrupt
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int ADDR     = 0,
    parameter int AWIDTH   = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    gpio_irq_if.slave  wb_dbus,
    input  logic [7:0] pins,
    output logic       irq
);

    logic       cyc;
    logic       ack;
    logic [7:0] filt;
    logic [7:0] filt_d;
    logic [7:0] rise_en;
    logic [7:0] fall_en;
    logic [7:0] status;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] clr;
    logic [7:0] rd_val;
    logic [1:0] idx;
    logic [7:0] wdat;
    logic       wr;
    logic       unused_bits;

    assign idx  = wb_dbus.adr[3:2];
    assign wdat = wb_dbus.dat[7:0];
    assign wr   = cyc & wb_dbus.we;

    // Byte enables, low address bits and upper write data carry no meaning here.
    assign unused_bits = &{1'b0, wb_dbus.sel, wb_dbus.adr, wb_dbus.dat[31:8]};

    chip_select #(
        .ADDR   (ADDR),
        .AWIDTH (AWIDTH)
    ) u_chip_select (
        .clk    (wb_clk),
        .rst    (wb_rst),
        .adr_hi (wb_dbus.adr[31 -: AWIDTH]),
        .req    (wb_dbus.cyc),
        .cyc    (cyc),
        .ack    (ack)
    );

    assign wb_dbus.ack = ack;

    for (genvar g = 0; g < 8; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE (DEBOUNCE)
        ) u_debounce_bit (
            .clk  (wb_clk),
            .rst  (wb_rst),
            .pin  (pins[g]),
            .filt (filt[g])
        );
    end

    // Masked edges of the filtered inputs and the write-1-to-clear pattern.
    always_comb begin
        rise = filt & ~filt_d & rise_en;
        fall = ~filt & filt_d & fall_en;
        clr  = '0;
        if (wr && idx == GPIO_IRQ_STATUS) begin
            clr = wdat;
        end
    end

    // Register file, sticky status (new edges beat a clear) and the irq level.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            filt_d  <= '0;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            irq     <= 1'b0;
        end else begin
            filt_d <= filt;
            status <= (status & ~clr) | rise | fall;
            irq    <= |status;
            if (wr && idx == GPIO_IRQ_RISE_EN) begin
                rise_en <= wdat;
            end
            if (wr && idx == GPIO_IRQ_FALL_EN) begin
                fall_en <= wdat;
            end
        end
    end

    // Read mux; the bus sees zero outside the acknowledged cycle so it can be OR-combined.
    always_comb begin
        rd_val = '0;
        case (idx)
            GPIO_IRQ_IN:      rd_val = filt;
            GPIO_IRQ_RISE_EN: rd_val = rise_en;
            GPIO_IRQ_FALL_EN: rd_val = fall_en;
            GPIO_IRQ_STATUS:  rd_val = status;
            default:          rd_val = '0;
        endcase
    end

    assign wb_dbus.rdt = ack ? {24'h0, rd_val} : 32'h0;

endmodule

// File: tb/tb_gpio_irq.sv
// tb/tb_gpio_irq.sv - randomized scoreboard bench for gpio_irq
module tb_gpio_irq;

    localparam int         DB   = 4;
    localparam logic [7:0] BASE = 8'h40;
    localparam logic [7:0] BAD  = 8'h13;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pins;
    logic       irq;

    gpio_irq_if wb_dbus();

    gpio_irq #(
        .ADDR     (BASE),
        .AWIDTH   (8),
        .DEBOUNCE (DB)
    ) dut (
        .wb_clk  (clk),
        .wb_rst  (rst),
        .wb_dbus (wb_dbus),
        .pins    (pins),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Request channel from driver to model.
    int         req_seq = 0;
    logic       req_we;
    logic [1:0] req_idx;
    logic [7:0] req_dat;

    // Reference model state.
    logic [7:0]  m_filt, m_filt_d, m_rise, m_fall, m_stat;
    logic        m_irq = 1'b0;
    logic        m_ack = 1'b0;
    logic [7:0]  hist [0:15];
    int          seen_seq = 0;
    int          m_age = 0;
    logic        m_we;
    logic [1:0]  m_idx;
    logic [7:0]  m_dat;
    logic [31:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_reg(input logic [1:0] i);
        case (i)
            2'd0:    return m_filt;
            2'd1:    return m_rise;
            2'd2:    return m_fall;
            default: return m_stat;
        endcase
    endfunction

    // Model: filtered value follows a pin once its last DB synchronised samples agree.
    initial forever begin : model
        logic       is_a, is_b;
        logic [7:0] r, f, clr, all1, any1;
        @(posedge clk);
        if (rst) begin
            m_filt = 0; m_filt_d = 0; m_rise = 0; m_fall = 0; m_stat = 0;
            m_irq = 0; m_ack = 0; m_age = 0; seen_seq = req_seq;
            for (int i = 0; i < 16; i++) hist[i] = 8'h00;
        end else begin
            is_b = (m_age == 1);
            is_a = (req_seq != seen_seq);
            if (is_a) begin
                seen_seq = req_seq;
                m_we = req_we; m_idx = req_idx; m_dat = req_dat;
            end
            r   = m_filt & ~m_filt_d & m_rise;
            f   = ~m_filt & m_filt_d & m_fall;
            clr = (is_b && m_we && m_idx == 2'd3) ? m_dat : 8'h00;
            m_irq    = |m_stat;
            m_stat   = (m_stat & ~clr) | r | f;
            m_filt_d = m_filt;
            for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pins;
            all1 = 8'hFF; any1 = 8'h00;
            for (int i = 2; i <= DB + 1; i++) begin
                all1 = all1 & hist[i];
                any1 = any1 | hist[i];
            end
            m_filt = (m_filt | all1) & any1;
            if (is_b && m_we && m_idx == 2'd1) m_rise = m_dat;
            if (is_b && m_we && m_idx == 2'd2) m_fall = m_dat;
            m_age = is_a ? 1 : 0;
            m_ack = is_a;
            if (is_a) sb.push_back({24'h0, model_reg(m_idx)});
        end
    end

    // Monitor: compare irq/ack every cycle and pop expected read data on each ack.
    initial forever begin : monitor
        logic [31:0] exp;
        @(negedge clk);
        check("irq", {31'h0, irq}, {31'h0, m_irq});
        check("ack", {31'h0, wb_dbus.ack}, {31'h0, m_ack});
        if (wb_dbus.ack) begin
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("rdt", wb_dbus.rdt, exp);
            end
        end else begin
            check("rdt_idle", wb_dbus.rdt, 32'h0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pins(input logic [7:0] v);
        @(negedge clk);
        pins = v;
    endtask

    task automatic bus_op(input logic we, input logic [1:0] idx, input logic [7:0] wd,
                          input logic [7:0] hi);
        @(negedge clk);
        wb_dbus.adr = {hi, 20'h0, idx, 2'b00};
        wb_dbus.dat = {24'($urandom), wd};
        wb_dbus.sel = 4'hF;
        wb_dbus.we  = we;
        wb_dbus.cyc = 1'b1;
        if (hi == BASE) begin
            req_we = we; req_idx = idx; req_dat = wd;
            req_seq++;
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        wb_dbus.cyc = 1'b0;
        wb_dbus.we  = 1'b0;
    endtask

    task automatic reset_during_write();
        @(negedge clk);
        wb_dbus.adr = {BASE, 20'h0, 2'd1, 2'b00};
        wb_dbus.dat = 32'h0000_003C;
        wb_dbus.we  = 1'b1;
        wb_dbus.cyc = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        wb_dbus.cyc = 1'b0;
        wb_dbus.we  = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : driver
        logic [7:0] v;
        rst = 1'b1;
        pins = 8'h00;
        wb_dbus.adr = '0; wb_dbus.dat = '0; wb_dbus.sel = '0;
        wb_dbus.we = 1'b0; wb_dbus.cyc = 1'b0;
        idle(3);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) bus_op(1'b0, 2'(i), 8'h00, BASE);

        // Rising edge on pin 0.
        bus_op(1'b1, 2'd1, 8'h01, BASE);
        set_pins(8'h01);
        idle(10);
        bus_op(1'b0, 2'd0, 8'h00, BASE);
        bus_op(1'b0, 2'd3, 8'h00, BASE);

        // Short glitch on pin 3.
        bus_op(1'b1, 2'd3, 8'hFF, BASE);
        bus_op(1'b1, 2'd1, 8'h08, BASE);
        bus_op(1'b1, 2'd2, 8'h08, BASE);
        set_pins(8'h09);
        idle(3);
        pins = 8'h01;
        idle(10);
        bus_op(1'b0, 2'd0, 8'h00, BASE);
        bus_op(1'b0, 2'd3, 8'h00, BASE);

        // Falling edge on pin 7, then clear.
        bus_op(1'b1, 2'd1, 8'h00, BASE);
        bus_op(1'b1, 2'd2, 8'h80, BASE);
        set_pins(8'h81);
        idle(10);
        set_pins(8'h01);
        idle(10);
        bus_op(1'b0, 2'd3, 8'h00, BASE);
        bus_op(1'b1, 2'd3, 8'h80, BASE);
        idle(2);
        bus_op(1'b0, 2'd3, 8'h00, BASE);

        // Falling edge landing on the clear cycle.
        set_pins(8'h81);
        idle(10);
        set_pins(8'h01);
        repeat (5) @(posedge clk);
        bus_op(1'b1, 2'd3, 8'h80, BASE);
        bus_op(1'b0, 2'd3, 8'h00, BASE);

        // Foreign address.
        bus_op(1'b0, 2'd1, 8'h00, BAD);
        bus_op(1'b1, 2'd1, 8'hFF, BAD);
        bus_op(1'b0, 2'd1, 8'h00, BASE);

        // Randomized traffic.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    v = pins ^ (8'h01 << $urandom_range(0, 7));
                    set_pins(v);
                    idle($urandom_range(1, 8));
                end
                1: bus_op(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), BASE);
                2: bus_op(1'b0, 2'($urandom_range(0, 3)), 8'h00, BASE);
                default: begin
                    v = pins;
                    set_pins(pins ^ (8'h01 << $urandom_range(0, 7)));
                    idle($urandom_range(1, DB + 1));
                    pins = v;
                    idle(2);
                end
            endcase
        end
        idle(12);
        bus_op(1'b0, 2'd0, 8'h00, BASE);
        bus_op(1'b0, 2'd3, 8'h00, BASE);

        // Reset in the middle of a write.
        reset_during_write();
        bus_op(1'b0, 2'd1, 8'h00, BASE);
        bus_op(1'b0, 2'd3, 8'h00, BASE);
        idle(4);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
